// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback (master) and the multi-port register file (slave).
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                resv_en;
  logic [AW-1:0]       resv_addr;
  logic [NREGS-1:0]    pending;
  logic                busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
    input  rd_data, pending, busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
    output rd_data, pending, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised N-read/M-write register file with post-reset clear sweep,
// optional write-to-read bypass and a per-register pending scoreboard.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave rf
);
  localparam int            AW      = $clog2(NREGS);
  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                clr_we;
  logic                idle;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    pending_q, pending_d;
  logic [NWR-1:0]      we_ok;
  logic [NRD*XLEN-1:0] rd_data_d;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                resv_en;
  logic [AW-1:0]       resv_addr;

  assign rd_addr   = rf.rd_addr;
  assign wr_en     = rf.wr_en;
  assign wr_addr   = rf.wr_addr;
  assign wr_data   = rf.wr_data;
  assign resv_en   = rf.resv_en;
  assign resv_addr = rf.resv_addr;

  // In range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    v = '0;
    if (idle && addr_ok(ra)) begin
      v = regs_q[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (we_ok[j] && (wr_addr[j*AW +: AW] == ra)) v = wr_data[j*XLEN +: XLEN];
        end
      end
    end
    return v;
  endfunction

  assign idle = (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    we_ok = '0;
    for (int j = 0; j < NWR; j++) begin
      we_ok[j] = idle && wr_en[j] && addr_ok(wr_addr[j*AW +: AW]);
    end
  end

  // Later ports overwrite earlier ones, so the highest index wins on conflict.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we_ok[j]) regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data_d[i*XLEN +: XLEN] = read_port(rd_addr[i*AW +: AW]);
    end
  end

  // Reserve is applied after the write clears: a new producer outranks the retiring one.
  always_comb begin
    pending_d = pending_q;
    if (idle) begin
      for (int j = 0; j < NWR; j++) begin
        if (we_ok[j]) pending_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (resv_en && addr_ok(resv_addr)) pending_d[resv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign rf.rd_data = rd_data_d;
  assign rf.pending = pending_q;
  assign rf.busy    = ~idle;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: DUT A (32 regs, 2W, bypass) and DUT B (24 regs, 1W, no bypass) share clk/rst.
module tb_regfile_mp;
  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   ca, cb, bad;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(1)) ifb ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst), .rf(ifa)
  );
  regfile_mp #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .rst(rst), .rf(ifb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clr_a();
    ifa.rd_addr = '0; ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.resv_en = 1'b0; ifa.resv_addr = '0;
  endtask

  task automatic clr_b();
    ifb.rd_addr = '0; ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.resv_en = 1'b0; ifb.resv_addr = '0;
  endtask

  // Counts busy samples per DUT from the current point; flags any nonzero read/pending while busy.
  task automatic sweep(output int na, output int nb, output int flag);
    na = 0; nb = 0; flag = 0;
    for (int k = 0; k < 200; k++) begin
      if (ifa.busy) begin
        na++;
        if (ifa.rd_data != '0 || ifa.pending != '0) flag = 1;
      end
      if (ifb.busy) begin
        nb++;
        if (ifb.rd_data != '0 || ifb.pending != '0) flag = 1;
      end else begin
        clr_b();
      end
      if (!ifa.busy && !ifb.busy) break;
      tick();
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; passed = 0; total = 0;
    clr_a(); clr_b();
    tick(); tick();
    chk("rst_busy_a", 64'(ifa.busy), 64'd1);
    chk("rst_busy_b", 64'(ifb.busy), 64'd1);
    chk("rst_pend_a", 64'(ifa.pending), 64'd0);
    chk("rst_pend_b", 64'(ifb.pending), 64'd0);

    // Sweep with writes/reserves/reads of x5 that must all be ignored.
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd5}; ifa.wr_data = {32'h0, 32'hDEADBEEF};
    ifa.rd_addr = {5'd5, 5'd5}; ifa.resv_en = 1'b1; ifa.resv_addr = 5'd5;
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd5; ifb.wr_data = 32'hDEADBEEF;
    ifb.rd_addr = {5'd5, 5'd5}; ifb.resv_en = 1'b1; ifb.resv_addr = 5'd5;
    rst = 1'b0;
    sweep(ca, cb, bad);
    clr_a(); clr_b();
    chk("sweep_len_a", 64'(ca), 64'd32);
    chk("sweep_len_b", 64'(cb), 64'd24);
    chk("sweep_quiet", 64'(bad), 64'd0);
    ifa.rd_addr = {5'd5, 5'd5}; ifb.rd_addr = {5'd5, 5'd5};
    #1;
    chk("x5_a_after_sweep", 64'(ifa.rd_data[31:0]), 64'd0);
    chk("x5_b_after_sweep", 64'(ifb.rd_data[31:0]), 64'd0);
    chk("pend_a_after_sweep", 64'(ifa.pending), 64'd0);
    chk("pend_b_after_sweep", 64'(ifb.pending), 64'd0);

    // Bypass (A) versus stored-value read (B).
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd7}; ifa.wr_data = {32'h0, 32'h12345678};
    ifa.rd_addr = {5'd0, 5'd7};
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd7; ifb.wr_data = 32'h12345678; ifb.rd_addr = {5'd0, 5'd7};
    #1;
    chk("bypass_a", 64'(ifa.rd_data[31:0]), 64'h12345678);
    chk("nobypass_b", 64'(ifb.rd_data[31:0]), 64'd0);
    tick();
    ifa.wr_en = '0; ifb.wr_en = '0;
    #1;
    chk("stored_a", 64'(ifa.rd_data[31:0]), 64'h12345678);
    chk("stored_b", 64'(ifb.rd_data[31:0]), 64'h12345678);

    // Zero register and same-address port conflict.
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd0}; ifa.wr_data = {32'h0, 32'hFFFFFFFF};
    ifa.rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_bypass", 64'(ifa.rd_data[63:32]), 64'd0);
    tick();
    ifa.wr_en = '0;
    #1;
    chk("x0_stored", 64'(ifa.rd_data[31:0]), 64'd0);
    ifa.wr_en = 2'b11; ifa.wr_addr = {5'd3, 5'd3}; ifa.wr_data = {32'hB, 32'hA};
    ifa.rd_addr = {5'd3, 5'd3};
    #1;
    chk("conflict_bypass", 64'(ifa.rd_data[31:0]), 64'hB);
    tick();
    ifa.wr_en = '0;
    #1;
    chk("conflict_rd0", 64'(ifa.rd_data[31:0]), 64'hB);
    chk("conflict_rd1", 64'(ifa.rd_data[63:32]), 64'hB);

    // Scoreboard.
    ifa.resv_en = 1'b1; ifa.resv_addr = 5'd9;
    tick();
    ifa.resv_en = 1'b0;
    chk("resv_x9", 64'(ifa.pending), 64'h200);
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd9}; ifa.wr_data = {32'h0, 32'h99};
    tick();
    ifa.wr_en = '0;
    chk("wr_clears_x9", 64'(ifa.pending), 64'h0);
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd9}; ifa.wr_data = {32'h0, 32'h77};
    ifa.resv_en = 1'b1; ifa.resv_addr = 5'd9;
    tick();
    ifa.wr_en = '0; ifa.resv_addr = 5'd0;
    chk("resv_beats_wr", 64'(ifa.pending), 64'h200);
    ifa.rd_addr = {5'd0, 5'd9};
    #1;
    chk("x9_data", 64'(ifa.rd_data[31:0]), 64'h77);
    tick();
    chk("resv_x0_ignored", 64'(ifa.pending), 64'h200);
    ifa.resv_addr = 5'd4;
    tick();
    ifa.resv_en = 1'b0;
    chk("resv_x4", 64'(ifa.pending), 64'h210);

    // Out-of-range handling on the 24-entry file.
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd30; ifb.wr_data = 32'hBAD;
    ifb.rd_addr = {5'd30, 5'd30}; ifb.resv_en = 1'b1; ifb.resv_addr = 5'd30;
    #1;
    chk("b_rd30_now", 64'(ifb.rd_data[31:0]), 64'd0);
    tick();
    ifb.wr_en = '0; ifb.resv_en = 1'b0;
    chk("b_resv30_pend", 64'(ifb.pending), 64'd0);
    chk("b_rd30_after", 64'(ifb.rd_data[63:32]), 64'd0);
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd23; ifb.wr_data = 32'h23;
    ifb.resv_en = 1'b1; ifb.resv_addr = 5'd23; ifb.rd_addr = {5'd0, 5'd23};
    tick();
    ifb.wr_en = '0; ifb.resv_en = 1'b0;
    chk("b_x23_data", 64'(ifb.rd_data[31:0]), 64'h23);
    chk("b_x23_pend", 64'(ifb.pending), 64'h800000);

    // Reset in IDLE, then a reset partway through the sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("idle_rst_pend_a", 64'(ifa.pending), 64'd0);
    chk("idle_rst_pend_b", 64'(ifb.pending), 64'd0);
    chk("idle_rst_busy_a", 64'(ifa.busy), 64'd1);
    repeat (10) tick();
    chk("mid_sweep_busy_a", 64'(ifa.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep(ca, cb, bad);
    chk("resweep_len_a", 64'(ca), 64'd32);
    chk("resweep_len_b", 64'(cb), 64'd24);
    chk("resweep_quiet", 64'(bad), 64'd0);
    clr_a(); clr_b();
    ifa.rd_addr = {5'd7, 5'd3}; ifb.rd_addr = {5'd7, 5'd23};
    #1;
    chk("a_x3_cleared", 64'(ifa.rd_data[31:0]), 64'd0);
    chk("a_x7_cleared", 64'(ifa.rd_data[63:32]), 64'd0);
    chk("b_x23_cleared", 64'(ifb.rd_data[31:0]), 64'd0);
    chk("b_x7_cleared", 64'(ifb.rd_data[63:32]), 64'd0);
    chk("a_pend_final", 64'(ifa.pending), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the riscv_core. Successor to the fixed 2R/1W, 32x32 register file.
- Adds configurable width and depth, N read and M write ports, and optional same-cycle write-to-read bypass.
- Adds a hardware clear sweep after reset and a per-register pending (scoreboard) bit for the issue stage.
- Sits between decode/issue (read ports, reservations) and writeback (write ports).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (>= 2); AW = $clog2(NREGS) is a localparam
NRD, 2, number of read ports
NWR, 1, number of write ports
BYPASS, 1, 1 = a read returns same-cycle write data to the same address; 0 = read returns stored value
ZERO_REG, 1, 1 = register 0 is hardwired to zero (writes ignored, reads 0, never pending)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN], combinational
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
resv_en  in  1  mark resv_addr pending
resv_addr  in  AW  register to reserve
pending  out  NREGS  scoreboard bit per register, registered
busy  out  1  clear sweep in progress, registered

Behaviour:
- States: CLEAR and IDLE, with sweep counter cnt (AW bits).
- Reset:
  - rst=1 at an edge -> state=CLEAR, cnt=0, busy=1, pending=all 0.
  - rst held high holds this state.
  - rst asserted mid-sweep restarts the sweep from cnt=0.
- CLEAR:
  - Each edge with rst=0 writes 0 to regs[cnt] and increments cnt.
  - The edge that writes regs[NREGS-1] moves the state to IDLE and sets busy=0.
  - busy is therefore high for exactly NREGS cycles after rst deasserts.
  - While in CLEAR: all rd_data=0, wr_en ignored, resv_en ignored, pending stays 0.
- IDLE writes:
  - For each port j with wr_en[j]=1 and wr_addr[j] < NREGS (and != 0 when ZERO_REG=1), regs[wr_addr[j]] <= wr_data[j] at the edge.
  - Multiple ports writing the same address: the highest-index port wins.
  - Out-of-range addresses are ignored.
- IDLE reads (combinational, zero latency):
  - rd_data[i]=0 if the address is out of range, or if the address is 0 with ZERO_REG=1.
  - Otherwise, with BYPASS=1 and any enabled, valid write port targeting the same address this cycle, return that port's wr_data (highest index wins).
  - Otherwise return regs[rd_addr[i]].
- Scoreboard (IDLE only):
  - An enabled valid write to register r clears pending[r] at the edge.
  - resv_en=1 with a valid resv_addr sets pending[resv_addr] at the edge.
  - Reserve and write to the same register in the same cycle: the reserve wins, pending stays 1 (new producer issued).
  - pending[0] is always 0 when ZERO_REG=1.
  - Reserving an already-pending register keeps it at 1.
- Width rules:
  - NREGS not a power of two: address values >= NREGS are out of range as defined above.
  - NRD, NWR >= 1.

Test Plan:
- Clear sweep: rst=1 for 2 cycles, then 0 -> busy=1 for exactly 32 cycles. During the sweep, a write of 0xDEADBEEF to x5 is ignored. After busy=0, reading x5 returns 0 and pending=0.
- Write/read with BYPASS=1: wr_en[0]=1, addr=7, data=0x12345678 -> rd_data[0] for addr 7 equals 0x12345678 in the same cycle. With BYPASS=0 it reads 0 that cycle and 0x12345678 the next.
- Zero register and port conflict (NWR=2): write x0=0xFFFFFFFF -> reads 0. Port0 writes x3=0xA and port1 writes x3=0xB in the same cycle -> x3 reads 0xB.
- Scoreboard: reserve x9 -> pending[9]=1 next cycle. A write to x9 clears it. Reserve x9 together with a write to x9 in the same cycle -> pending[9] remains 1.
- Mid-sweep reset: assert rst at cnt=10 -> sweep restarts, busy stays high 32 more cycles after deassert. Also assert rst in IDLE with pending[4]=1 -> pending cleared and registers read 0 after the sweep.
- NREGS=24: write to addr 30 is ignored, read of addr 30 returns 0, reserve of addr 30 leaves pending unchanged, and the sweep lasts 24 cycles.
